// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and execute-stage state encoding for alu_pipe.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_RESULT = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_exec_comb.sv
// Single-cycle ALU operations and {V,C,N,Z} flags; MUL is handled by the caller.
module alu_exec_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [SHW-1:0]   sh;
  logic             c;
  logic             v;

  always_comb begin
    sh   = b[SHW-1:0];
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    // Guard bit catches the last bit shifted out; it stays 0 for a zero shift.
    shl  = {1'b0, a} << sh;
    shr  = {a, 1'b0} >> sh;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = shl[WIDTH-1:0];
        c      = shl[WIDTH];
      end
      OP_SHR: begin
        result = shr[WIDTH:1];
        c      = shr[0];
      end
      default: result = '0;
    endcase
  end

  assign flags[FLG_Z] = (result == '0);
  assign flags[FLG_N] = result[WIDTH-1];
  assign flags[FLG_C] = c;
  assign flags[FLG_V] = v;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU: registered decode, then execute with an iterative shift-add multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             busy
);

  logic               vld_p1;
  logic [WIDTH-1:0]   a_p1;
  logic [WIDTH-1:0]   b_p1;
  logic [2:0]         op_p1;
  logic               mul_p1;

  exec_state_e        state_p2;
  exec_state_e        state_nxt;
  logic [WIDTH-1:0]   result_p2;
  logic [3:0]         flags_p2;
  logic [2*WIDTH-1:0] prod_p2;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mcand_p2;
  logic [SHW-1:0]     cnt_p2;
  logic [WIDTH:0]     psum;
  logic [3:0]         mul_flags;

  logic [WIDTH-1:0]   ex_result;
  logic [3:0]         ex_flags;
  logic               in_fire;
  logic               take_p2;
  logic               mul_done;

  assign in_fire   = in_valid && in_ready;
  assign take_p2   = vld_p1 && ((state_p2 == ST_IDLE) || ((state_p2 == ST_RESULT) && out_ready));
  assign in_ready  = !vld_p1 || take_p2;
  assign out_valid = (state_p2 == ST_RESULT);
  assign busy      = (state_p2 == ST_MULT);
  assign out_result = result_p2;
  assign out_flags  = flags_p2;

  // ---- stage 1: decode ----
  always_ff @(posedge clk) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (in_fire) vld_p1 <= 1'b1;
    else if (take_p2) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_p1   <= in_a;
      b_p1   <= in_b;
      op_p1  <= in_opcode;
      mul_p1 <= (in_opcode == OP_MUL);
    end
  end

  // ---- stage 2: execute ----
  alu_exec_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_exec (
    .a      (a_p1),
    .b      (b_p1),
    .op     (op_p1),
    .result (ex_result),
    .flags  (ex_flags)
  );

  // Product register holds {partial sum, remaining multiplier bits}; one bit retires per cycle.
  assign psum      = {1'b0, prod_p2[2*WIDTH-1:WIDTH]} + (prod_p2[0] ? {1'b0, mcand_p2} : '0);
  assign prod_nxt  = {psum, prod_p2[WIDTH-1:1]};
  assign mul_done  = (state_p2 == ST_MULT) && (cnt_p2 == SHW'(WIDTH - 1));
  assign mul_flags = {1'b0, |prod_nxt[2*WIDTH-1:WIDTH], prod_nxt[WIDTH-1], (prod_nxt[WIDTH-1:0] == '0)};

  always_comb begin
    state_nxt = state_p2;
    unique case (state_p2)
      ST_IDLE:   if (take_p2) state_nxt = mul_p1 ? ST_MULT : ST_RESULT;
      ST_MULT:   if (mul_done) state_nxt = ST_RESULT;
      ST_RESULT: begin
        if (out_ready) begin
          if (take_p2) state_nxt = mul_p1 ? ST_MULT : ST_RESULT;
          else         state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_p2 <= ST_IDLE;
    else     state_p2 <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p2    <= '0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (take_p2) begin
      if (mul_p1) begin
        cnt_p2 <= '0;
      end else begin
        result_p2 <= ex_result;
        flags_p2  <= ex_flags;
      end
    end else if (state_p2 == ST_MULT) begin
      if (mul_done) begin
        cnt_p2    <= '0;
        result_p2 <= prod_nxt[WIDTH-1:0];
        flags_p2  <= mul_flags;
      end else begin
        cnt_p2 <= cnt_p2 + SHW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_p2 && mul_p1) begin
      prod_p2  <= {{WIDTH{1'b0}}, b_p1};
      mcand_p2 <= a_p1;
    end else if (state_p2 == ST_MULT) begin
      prod_p2  <= prod_nxt;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8; flags shown as {V,C,N,Z}.
module tb_alu_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             busy;

  int nvec = 0;
  int nfail = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; out_ready = 1'b1;
    tick(); tick();
    nvec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 8'h00 || out_flags !== 4'h0) begin
      nfail++;
      $display("FAIL reset_state: valid=%b busy=%b result=%h flags=%b, want 0 0 00 0000",
               out_valid, busy, out_result, out_flags);
    end
    rst = 1'b0;
    tick();
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_overflow;
    present(3'b000, 8'h7F, 8'h01);
    tick();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++; $display("FAIL add_early_valid: got %b want 0", out_valid);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h80 || out_flags !== 4'b1010) begin
      nfail++;
      $display("FAIL add_7f_01: valid=%b result=%h flags=%b, want 1 80 1010", out_valid, out_result, out_flags);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++; $display("FAIL add_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    present(3'b001, 8'h05, 8'h05);
    tick();
    present(3'b001, 8'h03, 8'h05);
    tick();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'b0001) begin
      nfail++;
      $display("FAIL sub_5_5: valid=%b result=%h flags=%b, want 1 00 0001", out_valid, out_result, out_flags);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'hFE || out_flags !== 4'b0110) begin
      nfail++;
      $display("FAIL sub_3_5: valid=%b result=%h flags=%b, want 1 fe 0110", out_valid, out_result, out_flags);
    end
    tick();
  endtask

  task automatic test_mul;
    int busy_cnt;
    busy_cnt = 0;
    present(3'b111, 8'h10, 8'h20);
    tick();
    present(3'b000, 8'h01, 8'h01);
    tick();
    in_valid = 1'b0;
    nvec++;
    if (in_ready !== 1'b0) begin
      nfail++; $display("FAIL mul_s1_full_ready: got %b want 0", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1 && out_valid === 1'b0) busy_cnt++;
      tick();
    end
    nvec++;
    if (busy_cnt != 8 || busy !== 1'b0) begin
      nfail++; $display("FAIL mul_busy_cycles: got %0d busy cycles (busy now %b), want 8 (0)", busy_cnt, busy);
    end
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'b0101) begin
      nfail++;
      $display("FAIL mul_10_20: valid=%b result=%h flags=%b, want 1 00 0101", out_valid, out_result, out_flags);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h02 || out_flags !== 4'b0000) begin
      nfail++;
      $display("FAIL add_after_mul: valid=%b result=%h flags=%b, want 1 02 0000", out_valid, out_result, out_flags);
    end
    tick();
  endtask

  task automatic test_single_ops;
    logic [2:0] ops [9];
    logic [7:0] as  [9];
    logic [7:0] bs  [9];
    logic [7:0] ers [9];
    logic [3:0] efs [9];
    ops = '{3'b101, 3'b110, 3'b101, 3'b110, 3'b101, 3'b101, 3'b100, 3'b010, 3'b011};
    as  = '{8'h81,  8'h81,  8'h81,  8'h81,  8'h81,  8'h81,  8'hF0,  8'h0F,  8'h80};
    bs  = '{8'h01,  8'h01,  8'h00,  8'h00,  8'h03,  8'h09,  8'hFF,  8'hF0,  8'h01};
    ers = '{8'h02,  8'h40,  8'h81,  8'h81,  8'h08,  8'h02,  8'h0F,  8'h00,  8'h81};
    efs = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0010};
    for (int i = 0; i < 9; i++) begin
      present(ops[i], as[i], bs[i]);
      tick();
      in_valid = 1'b0;
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_result !== ers[i] || out_flags !== efs[i]) begin
        nfail++;
        $display("FAIL op%0d_%b_%h_%h: valid=%b result=%h flags=%b, want 1 %h %b",
                 i, ops[i], as[i], bs[i], out_valid, out_result, out_flags, ers[i], efs[i]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure;
    int accepted;
    int stable_bad;
    accepted = 0;
    stable_bad = 0;
    out_ready = 1'b0;
    present(3'b000, 8'h01, 8'h02);
    if (in_ready) accepted++;
    tick();
    present(3'b000, 8'h03, 8'h04);
    if (in_ready) accepted++;
    tick();
    present(3'b001, 8'h09, 8'h01);
    for (int i = 0; i < 3; i++) begin
      if (in_ready) accepted++;
      if (out_valid !== 1'b1 || out_result !== 8'h03) stable_bad++;
      tick();
    end
    nvec++;
    if (accepted != 2 || in_ready !== 1'b0) begin
      nfail++; $display("FAIL bp_accepts: accepted=%0d in_ready=%b, want 2 0", accepted, in_ready);
    end
    nvec++;
    if (stable_bad != 0 || out_result !== 8'h03 || out_valid !== 1'b1) begin
      nfail++; $display("FAIL bp_hold: unstable=%0d result=%h valid=%b, want 0 03 1", stable_bad, out_result, out_valid);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h07) begin
      nfail++; $display("FAIL bp_second: valid=%b result=%h, want 1 07", out_valid, out_result);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h08) begin
      nfail++; $display("FAIL bp_third: valid=%b result=%h, want 1 08", out_valid, out_result);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++; $display("FAIL bp_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul;
    present(3'b111, 8'h03, 8'h05);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    nvec++;
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL rmul_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 8'h00 || out_flags !== 4'h0) begin
      nfail++;
      $display("FAIL rmul_cleared: valid=%b busy=%b result=%h flags=%b, want 0 0 00 0000",
               out_valid, busy, out_result, out_flags);
    end
    rst = 1'b0;
    tick();
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nfail++; $display("FAIL rmul_ready: in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
    present(3'b000, 8'h02, 8'h03);
    tick();
    in_valid = 1'b0;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_result !== 8'h05 || out_flags !== 4'b0000) begin
      nfail++;
      $display("FAIL rmul_add_2_3: valid=%b result=%h flags=%b, want 1 05 0000", out_valid, out_result, out_flags);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mul();
    test_single_ops();
    test_backpressure();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
